// File: rtl/box_250mhz_p4_pkg.sv
// Shared definitions for the P4 box ingress/egress adapters: metadata field
// offsets, the metadata packer and the tkeep popcount helper.
package box_250mhz_p4_pkg;

    localparam int LEN_LSB  = 0;
    localparam int SRC_LSB  = 16;
    localparam int DST_LSB  = 32;
    localparam int SEQ_LSB  = 48;
    localparam int FIELD_W  = 16;
    localparam int META_W   = 64;
    // Widest tkeep the popcount helper accepts; narrower keeps are zero-extended.
    localparam int KEEP_MAX = 256;

    typedef logic [META_W-1:0] meta_t;

    function automatic logic [15:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + 16'(keep[i]);
        end
        return n;
    endfunction

    function automatic meta_t pack_meta(input logic [15:0] size, input logic [15:0] src,
                                        input logic [15:0] dst, input logic [15:0] seq);
        meta_t m;
        m = '0;
        m[LEN_LSB +: FIELD_W] = size;
        m[SRC_LSB +: FIELD_W] = src;
        m[DST_LSB +: FIELD_W] = dst;
        m[SEQ_LSB +: FIELD_W] = seq;
        return m;
    endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-Stream register slice: one output register plus one skid
// register, so upstream ready is registered yet throughput stays one beat/cycle.
module axis_skid_slice #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_payload,
    input  logic         out_ready
);

    logic         out_valid_reg, out_valid_next;
    logic         skid_valid_reg, skid_valid_next;
    logic         ready_reg;
    logic [W-1:0] out_payload_reg;
    logic [W-1:0] skid_payload_reg;
    logic         in_fire;
    logic         load_out_from_in, load_out_from_skid, load_skid;

    assign in_fire     = in_valid && ready_reg;
    assign in_ready    = ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_payload = out_payload_reg;

    always_comb begin
        out_valid_next     = out_valid_reg;
        skid_valid_next    = skid_valid_reg;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (!out_valid_reg || out_ready) begin
            // Ready is low whenever the skid holds a beat, so no input collides here.
            if (skid_valid_reg) begin
                load_out_from_skid = 1'b1;
                out_valid_next     = 1'b1;
                skid_valid_next    = 1'b0;
            end else begin
                load_out_from_in = in_fire;
                out_valid_next   = in_fire;
            end
        end else if (in_fire) begin
            load_skid       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= !skid_valid_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (load_out_from_skid) begin
            out_payload_reg <= skid_payload_reg;
        end else if (load_out_from_in) begin
            out_payload_reg <= in_payload;
        end
        if (load_skid) begin
            skid_payload_reg <= in_payload;
        end
    end

endmodule

// File: rtl/box_250mhz_p4_in.sv
// Ingress adapter into the P4 core: tags each packet with sideband metadata and
// a sequence number, checks tkeep length against tuser_size, and keeps stats.
module box_250mhz_p4_in #(
    parameter int TDATA_W    = 1024,
    parameter int USERMETA_W = 1088,
    parameter int SEQ_W      = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    input  logic [TDATA_W-1:0]      s_axis_tdata,
    input  logic [TDATA_W/8-1:0]    s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [15:0]             s_axis_tuser_size,
    input  logic [15:0]             s_axis_tuser_src,
    input  logic [15:0]             s_axis_tuser_dst,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [TDATA_W-1:0]      m_axis_tdata,
    output logic [TDATA_W/8-1:0]    m_axis_tkeep,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [USERMETA_W-1:0]   user_metadata_in,
    output logic                    user_metadata_in_valid,
    output logic [31:0]             stat_pkt_cnt,
    output logic [47:0]             stat_byte_cnt,
    output logic                    len_err,
    input  logic                    len_err_clr
);
    import box_250mhz_p4_pkg::*;

    localparam int KEEP_W = TDATA_W / 8;
    localparam int PAY_W  = 1 + META_W + 1 + KEEP_W + TDATA_W;

    localparam logic [0:0] ST_SOP = 1'b0;
    localparam logic [0:0] ST_MID = 1'b1;

    logic [0:0]       state_reg;
    logic [SEQ_W-1:0] seq_reg;
    meta_t            meta_reg;
    logic [15:0]      acc_reg;
    logic             len_err_reg;
    logic [31:0]      pkt_cnt_reg;
    logic [47:0]      byte_cnt_reg;

    logic             in_fire, out_fire, is_sop, len_bad, out_sop;
    meta_t            beat_meta, out_meta;
    logic [15:0]      beat_bytes, pkt_size, acc_sat;
    logic [16:0]      acc_sum;
    logic [PAY_W-1:0] in_payload, out_payload;

    assign is_sop   = (state_reg == ST_SOP);
    assign in_fire  = s_axis_tvalid && s_axis_tready;
    assign out_fire = m_axis_tvalid && m_axis_tready;

    // First beat takes live sideband; later beats reuse the latched copy.
    assign beat_meta = is_sop ? pack_meta(s_axis_tuser_size, s_axis_tuser_src,
                                          s_axis_tuser_dst, 16'(seq_reg))
                              : meta_reg;
    assign pkt_size  = beat_meta[LEN_LSB +: FIELD_W];

    assign beat_bytes = popcount(KEEP_MAX'(s_axis_tkeep));
    assign acc_sum    = {1'b0, (is_sop ? 16'd0 : acc_reg)} + {1'b0, beat_bytes};
    assign acc_sat    = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    assign len_bad    = in_fire && s_axis_tlast && (acc_sat != pkt_size);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg   <= ST_SOP;
            seq_reg     <= '0;
            meta_reg    <= '0;
            acc_reg     <= '0;
            len_err_reg <= 1'b0;
        end else begin
            if (in_fire) begin
                acc_reg   <= acc_sat;
                state_reg <= s_axis_tlast ? ST_SOP : ST_MID;
                if (is_sop) begin
                    meta_reg <= beat_meta;
                    seq_reg  <= seq_reg + SEQ_W'(1);
                end
            end
            if (len_bad) begin
                len_err_reg <= 1'b1;
            end else if (len_err_clr) begin
                len_err_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
        end else if (out_fire) begin
            byte_cnt_reg <= byte_cnt_reg + 48'(popcount(KEEP_MAX'(m_axis_tkeep)));
            if (m_axis_tlast) begin
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            end
        end
    end

    // Metadata and the SOP flag ride in the payload so they stay aligned with their beat.
    assign in_payload = {is_sop, beat_meta, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    axis_skid_slice #(
        .W(PAY_W)
    ) u_skid (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_valid    (s_axis_tvalid),
        .in_payload  (in_payload),
        .in_ready    (s_axis_tready),
        .out_valid   (m_axis_tvalid),
        .out_payload (out_payload),
        .out_ready   (m_axis_tready)
    );

    assign {out_sop, out_meta, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_payload;

    assign user_metadata_in       = {{(USERMETA_W-META_W){1'b0}}, out_meta};
    assign user_metadata_in_valid = m_axis_tvalid && out_sop;
    assign stat_pkt_cnt           = pkt_cnt_reg;
    assign stat_byte_cnt          = byte_cnt_reg;
    assign len_err                = len_err_reg;

endmodule

// File: tb/tb_box_250mhz_p4_in.sv
// Scoreboard bench for box_250mhz_p4_in: a driver pushes expected beats built
// from the sideband fields, an independent monitor pops them on output handshakes.
module tb_box_250mhz_p4_in;

    localparam int TDATA_W = 1024;
    localparam int KW      = TDATA_W / 8;
    localparam int UW      = 1088;
    localparam int SEQ_W   = 16;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic                s_axis_tvalid;
    logic [TDATA_W-1:0]  s_axis_tdata;
    logic [KW-1:0]       s_axis_tkeep;
    logic                s_axis_tlast;
    logic [15:0]         s_axis_tuser_size;
    logic [15:0]         s_axis_tuser_src;
    logic [15:0]         s_axis_tuser_dst;
    logic                s_axis_tready;
    logic                m_axis_tvalid;
    logic [TDATA_W-1:0]  m_axis_tdata;
    logic [KW-1:0]       m_axis_tkeep;
    logic                m_axis_tlast;
    logic                m_axis_tready;
    logic [UW-1:0]       user_metadata_in;
    logic                user_metadata_in_valid;
    logic [31:0]         stat_pkt_cnt;
    logic [47:0]         stat_byte_cnt;
    logic                len_err;
    logic                len_err_clr;

    always #5 aclk = ~aclk;

    box_250mhz_p4_in #(
        .TDATA_W    (TDATA_W),
        .USERMETA_W (UW),
        .SEQ_W      (SEQ_W)
    ) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tdata           (s_axis_tdata),
        .s_axis_tkeep           (s_axis_tkeep),
        .s_axis_tlast           (s_axis_tlast),
        .s_axis_tuser_size      (s_axis_tuser_size),
        .s_axis_tuser_src       (s_axis_tuser_src),
        .s_axis_tuser_dst       (s_axis_tuser_dst),
        .s_axis_tready          (s_axis_tready),
        .m_axis_tvalid          (m_axis_tvalid),
        .m_axis_tdata           (m_axis_tdata),
        .m_axis_tkeep           (m_axis_tkeep),
        .m_axis_tlast           (m_axis_tlast),
        .m_axis_tready          (m_axis_tready),
        .user_metadata_in       (user_metadata_in),
        .user_metadata_in_valid (user_metadata_in_valid),
        .stat_pkt_cnt           (stat_pkt_cnt),
        .stat_byte_cnt          (stat_byte_cnt),
        .len_err                (len_err),
        .len_err_clr            (len_err_clr)
    );

    typedef struct {
        logic [TDATA_W-1:0] data;
        logic [KW-1:0]      keep;
        logic               last;
        logic [63:0]        meta;
        logic               sop;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
    int          stall_cycles = 0;

    // Reference model state, derived from the packet-level rules.
    logic [15:0] m_seq;
    logic [31:0] m_pkts;
    logic [47:0] m_bytes;
    logic        m_len_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic chk_w(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] req);
        int fd;
        checks++;
        if (act !== req) begin
            errors++;
            fd = -1;
            for (int i = 0; i < UW; i++) begin
                if (fd < 0 && act[i] !== req[i]) fd = i;
            end
            $display("FAIL %s: got low64=%h required low64=%h (first differing bit %0d)",
                     nm, act[63:0], req[63:0], fd);
        end
    endtask

    always @(negedge aclk) begin
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            2:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: compares every output handshake and checks hold-while-stalled.
    beat_t              mon_e;
    logic               prev_stall = 1'b0;
    logic [TDATA_W-1:0] prev_data;
    logic [KW-1:0]      prev_keep;
    logic               prev_last, prev_mv;
    logic [UW-1:0]      prev_meta;

    always @(negedge aclk) begin
        #1;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
                chk_w("hold_data", UW'(m_axis_tdata), UW'(prev_data));
                chk_w("hold_keep", UW'(m_axis_tkeep), UW'(prev_keep));
                chk_w("hold_meta", user_metadata_in, prev_meta);
                chk("hold_last_mvalid", 64'({m_axis_tlast, user_metadata_in_valid}),
                    64'({prev_last, prev_mv}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got an output beat, required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_w("out_data", UW'(m_axis_tdata), UW'(mon_e.data));
                    chk_w("out_keep", UW'(m_axis_tkeep), UW'(mon_e.keep));
                    chk("out_last", 64'(m_axis_tlast), 64'(mon_e.last));
                    chk_w("out_meta", user_metadata_in, UW'(mon_e.meta));
                    chk("out_meta_valid", 64'(user_metadata_in_valid), 64'(mon_e.sop));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_last  = m_axis_tlast;
            prev_mv    = user_metadata_in_valid;
            prev_meta  = user_metadata_in;
        end
    end

    // Present one beat from a negedge; returns on the negedge after it is accepted.
    task automatic send_beat(input logic [TDATA_W-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [15:0] sz, input logic [15:0] sr,
                             input logic [15:0] ds, input logic [63:0] meta, input logic sop);
        int    w;
        beat_t e;
        s_axis_tvalid     = 1'b1;
        s_axis_tdata      = d;
        s_axis_tkeep      = k;
        s_axis_tlast      = l;
        s_axis_tuser_size = sz;
        s_axis_tuser_src  = sr;
        s_axis_tuser_dst  = ds;
        w = 0;
        while (!s_axis_tready && w < 200) begin
            @(negedge aclk);
            w++;
        end
        stall_cycles += w;
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL ingress_accept_timeout: got tready=0 for %0d cycles, required 1", w);
        end else begin
            e.data = d;
            e.keep = k;
            e.last = l;
            e.meta = meta;
            e.sop  = sop;
            exp_q.push_back(e);
        end
        @(negedge aclk);
    endtask

    task automatic send_pkt(input int nbytes, input bit sparse, input int size_delta,
                            input logic [15:0] src, input logic [15:0] dst,
                            input bit rnd, input bit gaps);
        logic [KW-1:0]      ks [0:7];
        logic [TDATA_W-1:0] d;
        logic [63:0]        meta;
        logic [15:0]        size, acc;
        int                 nb, rem, actual;
        nb     = (nbytes == 0) ? 1 : (nbytes + KW - 1) / KW;
        rem    = nbytes;
        actual = 0;
        for (int b = 0; b < nb; b++) begin
            ks[b] = '0;
            if (sparse) begin
                for (int i = 0; i < KW / 32; i++) ks[b][i*32 +: 32] = $urandom();
            end else begin
                for (int i = 0; i < KW && i < rem; i++) ks[b][i] = 1'b1;
            end
            rem    -= KW;
            actual += $countones(ks[b]);
        end
        size = 16'(actual + size_delta);
        meta = {m_seq, dst, src, size};
        acc  = (actual > 65535) ? 16'hFFFF : 16'(actual);
        if (acc != size) m_len_err = 1'b1;
        m_seq   = m_seq + 16'd1;
        m_pkts  = m_pkts + 32'd1;
        m_bytes = m_bytes + 48'(actual);
        for (int b = 0; b < nb; b++) begin
            d = '0;
            if (rnd) begin
                for (int i = 0; i < TDATA_W / 32; i++) d[i*32 +: 32] = $urandom();
            end else begin
                d[63:0] = meta ^ 64'(b);
            end
            // Sideband on non-first beats is junk and must be ignored.
            send_beat(d, ks[b], (b == nb - 1),
                      (b == 0) ? size : 16'($urandom()),
                      (b == 0) ? src  : 16'($urandom()),
                      (b == 0) ? dst  : 16'($urandom()),
                      meta, (b == 0));
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge aclk);
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && w < 1000) begin
            @(negedge aclk);
            w++;
        end
        if (w >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_pkt_cnt"}, 64'(stat_pkt_cnt), 64'(m_pkts));
        chk({nm, "_byte_cnt"}, 64'(stat_byte_cnt), 64'(m_bytes));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]        meta;
        logic [TDATA_W-1:0] d;

        aresetn           = 1'b0;
        s_axis_tvalid     = 1'b0;
        s_axis_tdata      = '0;
        s_axis_tkeep      = '0;
        s_axis_tlast      = 1'b0;
        s_axis_tuser_size = '0;
        s_axis_tuser_src  = '0;
        s_axis_tuser_dst  = '0;
        len_err_clr       = 1'b0;
        m_seq = '0; m_pkts = '0; m_bytes = '0; m_len_err = 1'b0;
        repeat (3) @(negedge aclk);

        // Reset state and ready rising one cycle after release.
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_meta_valid", 64'(user_metadata_in_valid), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk_stats("rst");
        aresetn = 1'b1;
        chk("rel_tready_before_edge", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        chk("rel_tready_after_edge", 64'(s_axis_tready), 64'd1);

        // Back-to-back 64B single-beat packets at full rate.
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) send_pkt(64, 0, 0, 16'(i), 16'(i + 100), 1, 0);
        wait_drain();
        chk("b2b_ingress_stalls", 64'(stall_cycles), 64'd0);
        chk_stats("b2b");

        // 150B two-beat packet with toggling backpressure.
        ready_mode = 1;
        send_pkt(150, 0, 0, 16'd1, 16'd2, 1, 0);
        wait_drain();
        ready_mode = 0;
        chk("len_ok_150", 64'(len_err), 64'd0);

        // Length mismatch: size 100, 96 bytes carried.
        send_pkt(96, 0, 4, 16'd3, 16'd4, 1, 0);
        chk("len_err_set", 64'(len_err), 64'd1);
        wait_drain();
        len_err_clr = 1'b1;
        @(negedge aclk);
        len_err_clr = 1'b0;
        chk("len_err_cleared", 64'(len_err), 64'd0);
        // Set and clear in the same cycle: set must win.
        len_err_clr = 1'b1;
        send_pkt(64, 0, 1, 16'd5, 16'd6, 1, 0);
        chk("len_err_set_wins", 64'(len_err), 64'd1);
        @(negedge aclk);
        len_err_clr = 1'b0;
        chk("len_err_cleared2", 64'(len_err), 64'd0);
        m_len_err = 1'b0;
        wait_drain();
        chk_stats("len");

        // Randomised packets, keeps, gaps and backpressure.
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send_pkt($urandom_range(0, 512), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 9) == 0) ? 1 : 0,
                     16'($urandom()), 16'($urandom()), 1, 1);
        end
        ready_mode = 0;
        wait_drain();
        chk("rand_len_err", 64'(len_err), 64'(m_len_err));
        chk_stats("rand");
        len_err_clr = 1'b1;
        @(negedge aclk);
        len_err_clr = 1'b0;
        m_len_err = 1'b0;

        // Run the sequence number up to the wrap point.
        while (m_seq != 16'hFFFE) send_pkt(64, 0, 0, 16'd7, 16'd8, 0, 0);
        for (int i = 0; i < 3; i++) send_pkt(64, 0, 0, 16'd9, 16'd10, 1, 0);
        wait_drain();
        chk_stats("wrap");

        // Reset while beat 2 of a 3-beat packet is presented.
        ready_mode = 3;
        repeat (2) @(negedge aclk);
        for (int i = 0; i < TDATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        meta = {m_seq, 16'd6, 16'd5, 16'd300};
        send_beat(d, '1, 1'b0, 16'd300, 16'd5, 16'd6, meta, 1'b1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = ~d;
        aresetn       = 1'b0;
        exp_q.delete();
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_meta_valid", 64'(user_metadata_in_valid), 64'd0);
        chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("midrst_len_err", 64'(len_err), 64'd0);
        aresetn = 1'b1;
        m_seq = '0; m_pkts = '0; m_bytes = '0; m_len_err = 1'b0;
        ready_mode = 0;
        repeat (2) @(negedge aclk);

        // Ten 64B packets after reset: seq restarts at 0, stats 10 / 640.
        for (int i = 0; i < 10; i++) send_pkt(64, 0, 0, 16'(i), 16'(2 * i), 1, 0);
        wait_drain();
        chk("stat_pkt_cnt_10", 64'(stat_pkt_cnt), 64'd10);
        chk("stat_byte_cnt_640", 64'(stat_byte_cnt), 64'd640);
        send_pkt(300, 0, 0, 16'd5, 16'd6, 1, 0);
        wait_drain();
        chk_stats("post_rst");
        chk("final_len_err", 64'(len_err), 64'(m_len_err));

        repeat (3) @(negedge aclk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/box_250mhz_p4_in.md
BOX_250MHZ_P4_IN -- requirements
Module: box_250mhz_p4_in

Interface
REQ-001 SHALL have parameter TDATA_W, default 1024, AXIS data width in bits.
REQ-002 SHALL have parameter USERMETA_W, default 1088, P4 user metadata width (1024+64).
REQ-003 SHALL have parameter SEQ_W, default 16, per-packet sequence number width.
REQ-004 aclk  input  1  single clock for all logic.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 s_axis_tvalid/tdata/tkeep/tlast  input  1/TDATA_W/TDATA_W/8/1  ingress packet stream.
REQ-007 s_axis_tuser_size/src/dst  input  16 each  per-packet sideband, sampled on first beat only.
REQ-008 s_axis_tready  output  1  ingress backpressure.
REQ-009 m_axis_tvalid/tdata/tkeep/tlast  output  1/TDATA_W/TDATA_W/8/1  stream to P4 core.
REQ-010 m_axis_tready  input  1  P4 core backpressure.
REQ-011 user_metadata_in  output  USERMETA_W  P4 input metadata, stable for whole packet.
REQ-012 user_metadata_in_valid  output  1  high only with the first beat of each packet.
REQ-013 stat_pkt_cnt  output  32  packets forwarded; stat_byte_cnt  output  48  bytes forwarded.
REQ-014 len_err  output  1  sticky: tkeep byte count disagreed with tuser_size; len_err_clr  input  1  clears it.

Function
REQ-015 Metadata SHALL be {zeros, seq[SEQ_W-1:0] at [63:48], tuser_dst at [47:32], tuser_src at [31:16], tuser_size at [15:0]}; bits above 63 SHALL be 0.
REQ-016 Data path SHALL be a 2-entry skid register: latency 1 cycle, full throughput (one beat per cycle under continuous valid/ready).
REQ-017 s_axis_tready SHALL be high whenever the skid entry is empty, independent of m_axis_tready same-cycle value.
REQ-018 m_axis_* SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 Input FSM SHALL have states SOP and MID; SOP->MID on accepted non-last beat; MID->SOP on accepted tlast; SOP->SOP on accepted single-beat packet.
REQ-020 In SOP, accepted beat SHALL latch sideband and current seq into metadata; seq SHALL increment by 1 per accepted first beat, wrapping 2^SEQ_W-1 -> 0.
REQ-021 Metadata SHALL travel with its beat through the skid so user_metadata_in_valid aligns exactly with the output first beat.
REQ-022 Byte count per beat SHALL be popcount(tkeep); per-packet accumulator 16 bits, saturating at 0xFFFF.
REQ-023 On accepted input tlast, if accumulated bytes (incl. that beat) != latched tuser_size, len_err SHALL set next cycle; packet SHALL still be forwarded unmodified.
REQ-024 len_err_clr and a new error in the same cycle: set SHALL win.
REQ-025 stat_pkt_cnt SHALL increment on each output tlast handshake; stat_byte_cnt SHALL add popcount(m_axis_tkeep) on each output handshake; both wrap.
REQ-026 tvalid=1 with tkeep=0 SHALL be forwarded and count 0 bytes.

Reset
REQ-027 While aresetn=0 at a clock edge: m_axis_tvalid=0, user_metadata_in_valid=0, s_axis_tready=0, FSM=SOP, seq=0, counters=0, len_err=0, skid empty.
REQ-028 s_axis_tready SHALL rise the first cycle after aresetn returns high.
REQ-029 Reset mid-packet SHALL discard buffered beats; the next accepted beat SHALL be treated as SOP.

Structure
REQ-030 Metadata field offsets (LEN_LSB=0, SRC_LSB=16, DST_LSB=32, SEQ_LSB=48) SHALL live in shared package box_250mhz_p4_pkg, also used by box_250mhz_p4_out.
REQ-031 Skid buffer SHALL be a sub-module axis_skid_slice, parameterised on payload width (data+keep+last+meta+sop).
REQ-032 Popcount SHALL be a function in box_250mhz_p4_pkg.

Verification
REQ-033 Back-to-back 64B single-beat packets, ready=1 -> one output beat per cycle, seq 0,1,2..., metadata_valid every beat.
REQ-034 150B packet (2 beats, tuser_size=150, src=1, dst=2) with m_axis_tready toggling 1/0 -> data and metadata unchanged while stalled; metadata_valid only on beat 1.
REQ-035 tuser_size=100, actual 96 bytes -> len_err=1 next cycle after tlast, packet forwarded; pulse len_err_clr -> 0.
REQ-036 Seq preset near wrap, 3 packets -> metadata seq 0xFFFE, 0xFFFF, 0x0000.
REQ-037 Reset asserted on beat 2 of a 3-beat packet -> outputs idle; following packet has correct metadata and seq 0.
REQ-038 10 packets of 64B -> stat_pkt_cnt=10, stat_byte_cnt=640.
